ram_arbiter_2port: RTL
======================

RAM_ARBITER_2PORT -- requirements
Module: ram_arbiter_2port

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: word width of the shared RAM.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10: address width of the shared RAM.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, legal range 1..15: maximum consecutive grants to one port while the other is requesting.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have the following ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- a_req, b_req  in  1  per-port access request.
- a_we, b_we  in  1  1 = write, 0 = read; qualified by req.
- a_addr, b_addr  in  ADDR_WIDTH  access address.
- a_d, b_d  in  DATA_WIDTH  write data.
- a_gnt, b_gnt  out  1  access accepted this cycle.
- a_rvalid, b_rvalid  out  1  read data valid this cycle.
- a_q, b_q  out  DATA_WIDTH  read data.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_d  out  DATA_WIDTH  RAM write data.
- ram_q  in  DATA_WIDTH  RAM read data; the RAM registers the address, so data appears 1 cycle after the address.

Function
REQ-006 The FSM SHALL have three states: IDLE, OWN_A and OWN_B; it SHALL hold a 4-bit burst counter burst_cnt and a 1-bit last_served pointer.
REQ-007 Each cycle, the port that is granted SHALL be decided combinationally from the state, a_req and b_req.
- At most one of a_gnt and b_gnt SHALL be high in any cycle.
- A port's gnt SHALL be high only while that port's req is high.
REQ-008 Grant rules:
- IDLE: exactly one requester is granted; both requesting → the port other than last_served.
- OWN_X: X is granted while X requests and (other port idle or burst_cnt < MAX_BURST); otherwise the other port, if requesting.
- No request → no grant.
REQ-009 Next-state rules:
- Next state = OWN_<granted port>, or IDLE if no grant.
- burst_cnt = 1 on an ownership change; incremented (saturating at 15) on a repeated grant to the same port.
- last_served updates to the granted port.
REQ-010 RAM drive:
- ram_addr and ram_d SHALL mux from the granted port, and from port A when no port is granted.
- ram_we = (a_gnt & a_we) | (b_gnt & b_we); it SHALL never be high without a grant.
REQ-011 A granted read SHALL produce <port>_rvalid = 1 exactly one cycle after the grant; rvalid SHALL be a register.
REQ-012 a_q and b_q SHALL both equal ram_q every cycle; consumers qualify with rvalid.
REQ-013 Back-to-back reads SHALL be supported:
- Full throughput, one access per cycle.
- rvalid ordering matches grant ordering.
REQ-014 A requester whose req is high and gnt is low SHALL hold we, addr and d stable until granted; the block does not buffer requests.
REQ-015 A write followed next cycle by a read of the same address SHALL return the new data (RAM read-after-write); the block SHALL add no forwarding.

Reset
REQ-016 While reset_n = 0 the block SHALL set:
- state = IDLE, burst_cnt = 0, last_served = B (so A wins the first tie);
- a_rvalid = b_rvalid = 0; a_gnt = b_gnt = 0; ram_we = 0.
REQ-017 Reset asserted mid-burst or with a read pending SHALL drop the pending rvalid; no rvalid SHALL appear after reset release for accesses granted before reset.
REQ-018 The first grant SHALL be possible in the first clock edge after reset_n deasserts.

Configuration
REQ-019 Macro RAM_ARB_FIXED_PRIO_EN, defined:
- Port A always wins when both ports request; MAX_BURST and last_served are ignored.
- burst_cnt may be removed.
REQ-020 With RAM_ARB_FIXED_PRIO_EN undefined, the round-robin and burst-limit behaviour of REQ-008/REQ-009 applies.

Verification
REQ-021 Reset, then A writes 0x5A at addr 3, then A reads addr 3 → ram_we = 1 only in the write cycle; a_rvalid = 1 one cycle after the read grant with a_q = 0x5A.
REQ-022 a_req and b_req rise together from IDLE after reset → a_gnt first; with both held, A gets 4 consecutive grants, then B gets 4, alternating (MAX_BURST = 4).
REQ-023 B alone streams reads at addrs 0..7 → b_gnt high 8 cycles; b_rvalid high 8 cycles delayed by 1; data in address order; a_rvalid stays 0.
REQ-024 reset_n pulsed low one cycle after a granted read → a_rvalid and b_rvalid stay 0 after release; state IDLE; next tie goes to A.
REQ-025 RAM_ARB_FIXED_PRIO_EN defined, both ports requesting for 10 cycles → a_gnt = 1 all 10 cycles; b_gnt = 0 until a_req drops, then B is granted in the same cycle.
REQ-026 Random req/we/addr traffic for 10000 cycles, checked against a reference memory model → no double grant, no ram_we without grant, all read data correct.

Source files
------------

// File: rtl/ram_arbiter_2port.sv
// Two-port arbiter in front of one single-port synchronous RAM (round-robin with burst limit).
// Define RAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority.
module ram_arbiter_2port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  b_req,
  input  logic                  a_we,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] a_d,
  input  logic [DATA_WIDTH-1:0] b_d,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_q,
  output logic [DATA_WIDTH-1:0] b_q,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [3:0] MAX_BURST_CNT = 4'(MAX_BURST);

  state_t     state, state_next;
  logic [3:0] burst_cnt, burst_cnt_next, burst_inc;
  logic       last_served, last_served_next;  // 1 = port B

  assign burst_inc = (burst_cnt == 4'd15) ? 4'd15 : burst_cnt + 4'd1;

  // Grants are suppressed while reset is asserted so no access leaks out.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (reset_n) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      if (a_req)
        a_gnt = 1'b1;
      else if (b_req)
        b_gnt = 1'b1;
`else
      case (state)
        OWN_A: begin
          if (a_req && (!b_req || burst_cnt < MAX_BURST_CNT))
            a_gnt = 1'b1;
          else if (b_req)
            b_gnt = 1'b1;
        end
        OWN_B: begin
          if (b_req && (!a_req || burst_cnt < MAX_BURST_CNT))
            b_gnt = 1'b1;
          else if (a_req)
            a_gnt = 1'b1;
        end
        default: begin
          if (a_req && b_req) begin
            a_gnt = last_served;
            b_gnt = !last_served;
          end else begin
            a_gnt = a_req;
            b_gnt = b_req;
          end
        end
      endcase
`endif
    end
  end

  always_comb begin
    state_next       = IDLE;
    burst_cnt_next   = burst_cnt;
    last_served_next = last_served;
    if (a_gnt) begin
      state_next       = OWN_A;
      last_served_next = 1'b0;
      burst_cnt_next   = (state == OWN_A) ? burst_inc : 4'd1;
    end else if (b_gnt) begin
      state_next       = OWN_B;
      last_served_next = 1'b1;
      burst_cnt_next   = (state == OWN_B) ? burst_inc : 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      burst_cnt   <= 4'd0;
      last_served <= 1'b1;
      a_rvalid    <= 1'b0;
      b_rvalid    <= 1'b0;
    end else begin
      state       <= state_next;
      burst_cnt   <= burst_cnt_next;
      last_served <= last_served_next;
      a_rvalid    <= a_gnt & ~a_we;
      b_rvalid    <= b_gnt & ~b_we;
    end
  end

  // Port A is the default mux leg when nobody is granted.
  assign ram_we   = (a_gnt & a_we) | (b_gnt & b_we);
  assign ram_addr = b_gnt ? b_addr : a_addr;
  assign ram_d    = b_gnt ? b_d : a_d;
  assign a_q      = ram_q;
  assign b_q      = ram_q;

endmodule
